pwm_fade_sequencer: RTL and testbench

- Autonomous fade/ramp controller that drives the duty-register write port (we, ch_sel, duty_in) of the 3-channel PWM block.
- Keeps a shadow "current" duty and a "target" duty per channel. On each fade tick it steps every non-settled channel toward its target by STEP.
- A host write requester shares the same write port and has fixed priority over the fade engine.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_tick_gen.sv | 27 ++
 rtl/pwm_fade_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared widths, reset duty values and fade FSM state type for the PWM fade sequencer.
package pwm_pkg;

    localparam int DUTY_W = 8;
    localparam int NUM_CH = 3;

    localparam logic [DUTY_W-1:0] DUTY0_RST = 8'd64;
    localparam logic [DUTY_W-1:0] DUTY1_RST = 8'd128;
    localparam logic [DUTY_W-1:0] DUTY2_RST = 8'd192;

    localparam logic [1:0] CH_NONE = 2'd3;

    typedef enum logic {
        IDLE,
        SCAN
    } fade_state_t;

    function automatic logic [DUTY_W-1:0] duty_rst(input int ch);
        case (ch)
            0:       return DUTY0_RST;
            1:       return DUTY1_RST;
            default: return DUTY2_RST;
        endcase
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Fade tick generator: down-counter that fires one tick every TICK_DIV enabled cycles.
module pwm_tick_gen #(
    parameter int TICK_DIV = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    // Disabled periods park the counter at reload so re-enabling restarts a full period.
    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Fade/ramp controller driving the 3-channel PWM duty write port, with host write priority.
// Optional done_irq output (pulse on busy falling) when PWM_FADE_DONE_IRQ_EN is defined.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int TICK_DIV = 256,
    parameter int STEP     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tgt_wr,
    input  logic [1:0]        tgt_ch,
    input  logic [DUTY_W-1:0] tgt_val,
    input  logic              host_req,
    input  logic [1:0]        host_ch,
    input  logic [DUTY_W-1:0] host_val,
    output logic              host_gnt,
    output logic              we,
    output logic [1:0]        ch_sel,
    output logic [DUTY_W-1:0] duty_in,
    output logic              busy,
    output logic [DUTY_W-1:0] cur0,
    output logic [DUTY_W-1:0] cur1,
    output logic [DUTY_W-1:0] cur2
`ifdef PWM_FADE_DONE_IRQ_EN
    ,
    output logic              done_irq
`endif
);

    localparam logic [DUTY_W:0]   STEP9 = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W-1:0] STEP8 = DUTY_W'(STEP);

    fade_state_t       state, state_n;
    logic [1:0]        idx, idx_n;
    logic [DUTY_W-1:0] cur_q [NUM_CH];
    logic [DUTY_W-1:0] tgt_q [NUM_CH];
    logic [DUTY_W-1:0] cur_n [NUM_CH];
    logic [DUTY_W-1:0] tgt_n [NUM_CH];
    logic              we_n, gnt_n, busy_n;
    logic [1:0]        ch_n;
    logic [DUTY_W-1:0] duty_n;
    logic [DUTY_W-1:0] sel_cur, sel_tgt, nxt;
    logic [DUTY_W:0]   diff;
    logic              host_win;
    logic              tick;

    pwm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign host_win = host_req && !host_gnt;

    // One step of the channel under scan, clamped so it lands exactly on the target.
    always_comb begin
        sel_cur = cur_q[0];
        sel_tgt = tgt_q[0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == 2'(i)) begin
                sel_cur = cur_q[i];
                sel_tgt = tgt_q[i];
            end
        end
        diff = '0;
        nxt  = sel_cur;
        if (sel_tgt > sel_cur) begin
            diff = {1'b0, sel_tgt} - {1'b0, sel_cur};
            nxt  = (diff <= STEP9) ? sel_tgt : sel_cur + STEP8;
        end else if (sel_tgt < sel_cur) begin
            diff = {1'b0, sel_cur} - {1'b0, sel_tgt};
            nxt  = (diff <= STEP9) ? sel_tgt : sel_cur - STEP8;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        we_n    = 1'b0;
        ch_n    = ch_sel;
        duty_n  = duty_in;
        gnt_n   = 1'b0;
        busy_n  = 1'b0;
        cur_n   = cur_q;
        tgt_n   = tgt_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (tgt_wr && tgt_ch == 2'(i)) begin
                tgt_n[i] = tgt_val;
            end
        end

        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = SCAN;
                    idx_n   = 2'd0;
                end
            end
            SCAN: begin
                // A host cycle stalls the scan so this channel is revisited next cycle.
                if (!host_win) begin
                    if (sel_cur != sel_tgt) begin
                        we_n   = 1'b1;
                        ch_n   = idx;
                        duty_n = nxt;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (idx == 2'(i)) begin
                                cur_n[i] = nxt;
                            end
                        end
                    end
                    if (idx == 2'(NUM_CH - 1)) begin
                        state_n = IDLE;
                        idx_n   = 2'd0;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 2'd0;
            end
        endcase

        if (host_win) begin
            gnt_n = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (host_ch == 2'(i)) begin
                    we_n     = 1'b1;
                    ch_n     = host_ch;
                    duty_n   = host_val;
                    cur_n[i] = host_val;
                    tgt_n[i] = host_val;
                end
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            busy_n = busy_n | (cur_n[i] != tgt_n[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            we       <= 1'b0;
            ch_sel   <= 2'd0;
            duty_in  <= '0;
            host_gnt <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_q[i] <= duty_rst(i);
                tgt_q[i] <= duty_rst(i);
            end
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            we       <= we_n;
            ch_sel   <= ch_n;
            duty_in  <= duty_n;
            host_gnt <= gnt_n;
            busy     <= busy_n;
            cur_q    <= cur_n;
            tgt_q    <= tgt_n;
        end
    end

    assign cur0 = cur_q[0];
    assign cur1 = cur_q[1];
    assign cur2 = cur_q[2];

`ifdef PWM_FADE_DONE_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            done_irq <= 1'b0;
        end else begin
            done_irq <= busy && !busy_n;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pwm_fade_sequencer;

    localparam int TD = 8;
    localparam int ST = 16;

    logic       clk = 1'b0;
    logic       rst, enable, tgt_wr, host_req;
    logic [1:0] tgt_ch, host_ch;
    logic [7:0] tgt_val, host_val;
    logic       host_gnt, we, busy;
    logic [1:0] ch_sel;
    logic [7:0] duty_in, cur0, cur1, cur2;
`ifdef PWM_FADE_DONE_IRQ_EN
    logic       done_irq;
`endif

    pwm_fade_sequencer #(
        .TICK_DIV (TD),
        .STEP     (ST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .tgt_wr   (tgt_wr),
        .tgt_ch   (tgt_ch),
        .tgt_val  (tgt_val),
        .host_req (host_req),
        .host_ch  (host_ch),
        .host_val (host_val),
        .host_gnt (host_gnt),
        .we       (we),
        .ch_sel   (ch_sel),
        .duty_in  (duty_in),
        .busy     (busy),
        .cur0     (cur0),
        .cur1     (cur1),
        .cur2     (cur2)
`ifdef PWM_FADE_DONE_IRQ_EN
        ,
        .done_irq (done_irq)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int wlog[$];
    int irq_cnt = 0;

    // Reference model: integer duties, scan position -1 when idle.
    int m_cur[3], m_tgt[3];
    int m_cnt, m_scan, m_ch, m_duty;
    bit m_gnt, m_we, m_busy, m_irq;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur  = '{64, 128, 192};
        m_tgt  = '{64, 128, 192};
        m_cnt  = TD - 1;
        m_scan = -1;
        m_gnt  = 0;
        m_we   = 0;
        m_ch   = 0;
        m_duty = 0;
        m_busy = 0;
        m_irq  = 0;
    endtask

    function automatic int toward(input int c, input int t);
        int d;
        d = t - c;
        if (d > ST)  d = ST;
        if (d < -ST) d = -ST;
        return c + d;
    endfunction

    task automatic model_edge();
        int oc[3], ot[3];
        bit tk, hw, prev;
        if (rst) begin
            model_reset();
            return;
        end
        oc = m_cur;
        ot = m_tgt;
        tk = (m_cnt == 0) && enable;
        m_cnt = (!enable || tk) ? TD - 1 : m_cnt - 1;
        hw = host_req && !m_gnt;
        m_gnt = hw;
        m_we = 0;
        if (tgt_wr && tgt_ch != 2'd3) m_tgt[tgt_ch] = int'(tgt_val);
        if (m_scan >= 0) begin
            if (!hw) begin
                if (oc[m_scan] != ot[m_scan]) begin
                    m_cur[m_scan] = toward(oc[m_scan], ot[m_scan]);
                    m_we = 1;
                    m_ch = m_scan;
                    m_duty = m_cur[m_scan];
                end
                m_scan = (m_scan == 2) ? -1 : m_scan + 1;
            end
        end else if (tk) begin
            m_scan = 0;
        end
        if (hw && host_ch != 2'd3) begin
            m_we = 1;
            m_ch = int'(host_ch);
            m_duty = int'(host_val);
            m_cur[host_ch] = int'(host_val);
            m_tgt[host_ch] = int'(host_val);
        end
        prev = m_busy;
        m_busy = (m_cur[0] != m_tgt[0]) || (m_cur[1] != m_tgt[1]) || (m_cur[2] != m_tgt[2]);
        m_irq = prev && !m_busy;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_val("we", we, m_we);
        if (m_we) begin
            check_val("ch_sel", ch_sel, m_ch);
            check_val("duty_in", duty_in, m_duty);
        end
        check_val("host_gnt", host_gnt, m_gnt);
        check_val("busy", busy, m_busy);
        check_val("cur0", cur0, m_cur[0]);
        check_val("cur1", cur1, m_cur[1]);
        check_val("cur2", cur2, m_cur[2]);
`ifdef PWM_FADE_DONE_IRQ_EN
        check_val("done_irq", done_irq, m_irq);
        if (done_irq === 1'b1) irq_cnt++;
`endif
        if (we === 1'b1) wlog.push_back(int'(ch_sel) * 256 + int'(duty_in));
    endtask

    task automatic pulse_tgt(input int ch, input int val);
        tgt_wr = 1'b1;
        tgt_ch = 2'(ch);
        tgt_val = 8'(val);
        cyc();
        tgt_wr = 1'b0;
    endtask

    task automatic wait_settle(input int max);
        int n = 0;
        while ((m_busy || m_scan >= 0) && n < max) begin
            cyc();
            n++;
        end
        if (n >= max) check_val("settle_timeout", 1, 0);
    endtask

    task automatic wait_scan0(input int max);
        int n = 0;
        while (m_scan != 0 && n < max) begin
            cyc();
            n++;
        end
        if (n >= max) check_val("scan_timeout", 1, 0);
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check_val({tag, "_len"}, wlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
            check_val(tag, wlog[i], exp[i]);
        end
    endtask

    initial begin
        int eq[$];
        rst = 1'b1; enable = 1'b0; tgt_wr = 1'b0; tgt_ch = 2'd0; tgt_val = 8'd0;
        host_req = 1'b0; host_ch = 2'd3; host_val = 8'd0;
        model_reset();
        cyc();
        cyc();
        check_val("rst_we", we, 0);
        check_val("rst_ch_sel", ch_sel, 0);
        check_val("rst_duty_in", duty_in, 0);
        check_val("rst_gnt", host_gnt, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_cur0", cur0, 64);
        check_val("rst_cur1", cur1, 128);
        check_val("rst_cur2", cur2, 192);
        rst = 1'b0;

        // Basic fade on ch0.
        enable = 1'b1;
        wlog.delete();
        irq_cnt = 0;
        pulse_tgt(0, 128);
        check_val("s1_busy_rise", busy, 1);
        wait_settle(200);
        eq = {80, 96, 112, 128};
        check_log("s1_writes", eq);
        check_val("s1_busy_end", busy, 0);
`ifdef PWM_FADE_DONE_IRQ_EN
        check_val("s1_irq_count", irq_cnt, 1);
`endif

        // Saturation up and down.
        wlog.delete();
        pulse_tgt(1, 135);
        wait_settle(200);
        eq = {256 + 135};
        check_log("s2_ch1", eq);
        wlog.delete();
        pulse_tgt(2, 0);
        wait_settle(400);
        eq.delete();
        for (int v = 176; v >= 16; v -= 16) eq.push_back(512 + v);
        eq.push_back(512);
        check_log("s2_ch2", eq);

        // Host write preempts the ch0 scan slot.
        pulse_tgt(0, 0);
        wait_scan0(100);
        host_req = 1'b1; host_ch = 2'd2; host_val = 8'd50;
        cyc();
        host_req = 1'b0;
        check_val("h_gnt", host_gnt, 1);
        check_val("h_we", we, 1);
        check_val("h_ch", ch_sel, 2);
        check_val("h_duty", duty_in, 50);
        cyc();
        check_val("h_fade_we", we, 1);
        check_val("h_fade_ch", ch_sel, 0);
        check_val("h_gnt_low", host_gnt, 0);
        check_val("h_cur2", cur2, 50);
        wait_settle(400);
        host_req = 1'b1; host_ch = 2'd3; host_val = 8'd99;
        cyc();
        host_req = 1'b0;
        check_val("hn_gnt", host_gnt, 1);
        check_val("hn_we", we, 0);
        cyc();

        // Disabled engine holds, then resumes from the held value.
        enable = 1'b0;
        wlog.delete();
        pulse_tgt(0, 40);
        repeat (4 * TD) cyc();
        check_val("en0_writes", wlog.size(), 0);
        check_val("en0_busy", busy, 1);
        enable = 1'b1;
        wait_settle(200);
        eq = {16, 32, 40};
        check_log("en1_writes", eq);

        // Reset in the first scan cycle after a tick.
        pulse_tgt(1, 0);
        wait_scan0(100);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_val("mr_we", we, 0);
        check_val("mr_busy", busy, 0);
        check_val("mr_cur0", cur0, 64);
        check_val("mr_cur1", cur1, 128);
        check_val("mr_cur2", cur2, 192);
        wlog.delete();
        repeat (30) cyc();
        check_val("mr_no_writes", wlog.size(), 0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom % 400) == 0;
            enable = ($urandom % 8) != 0;
            tgt_wr = ($urandom % 6) == 0;
            tgt_ch = 2'($urandom % 4);
            tgt_val = 8'($urandom);
            if (m_gnt) begin
                host_req = 1'b0;
            end else begin
                host_req = ($urandom % 5) == 0;
                host_ch = 2'($urandom % 4);
                host_val = 8'($urandom);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
